// File: rtl/fc_argmax_comparator.sv
// fc_argmax_comparator
// Streaming arg-max over the class scores of the fully-connected layer.
// Scores arrive serially in class order, one per valid_in cycle. The cycle
// after the last score of a frame, decision/max_score carry the winning
// class and its score, and valid_out pulses for one cycle. Equal scores
// keep the lower class index.

module fc_argmax_comparator #(
    parameter int INPUT_BITS = 12,
    parameter int NUM_CLASS  = 10,
    parameter int INDEX_BITS = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         valid_in,
    input  logic signed [INPUT_BITS-1:0] data_in,
    output logic        [INDEX_BITS-1:0] decision,
    output logic signed [INPUT_BITS-1:0] max_score,
    output logic                         valid_out
);

    localparam logic [INDEX_BITS-1:0] LAST_IDX = INDEX_BITS'(NUM_CLASS - 1);

    // Frame progress and running winner
    logic        [INDEX_BITS-1:0] cnt;
    logic signed [INPUT_BITS-1:0] run_max;
    logic        [INDEX_BITS-1:0] run_idx;

    // Winner after including the current sample
    logic                         take_new;
    logic signed [INPUT_BITS-1:0] win_val;
    logic        [INDEX_BITS-1:0] win_idx;
    logic                         is_last;

    // Decide whether the incoming score replaces the running winner
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned, which would infer a latch.
        take_new = 1'b0;
        win_val  = run_max;
        win_idx  = run_idx;
        is_last  = (cnt == LAST_IDX);
        // Score 0 always seeds the frame; later scores must be strictly larger,
        // so ties keep the lower index.
        if (cnt == '0 || data_in > run_max) begin
            take_new = 1'b1;
        end
        if (take_new) begin
            win_val = data_in;
            win_idx = cnt;
        end
    end

    // Running maximum, sample counter and result registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt       <= '0;
            run_max   <= '0;
            run_idx   <= '0;
            decision  <= '0;
            max_score <= '0;
            valid_out <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the pre-edge values of the others.
            valid_out <= 1'b0;
            if (valid_in) begin
                run_max <= win_val;
                run_idx <= win_idx;
                if (is_last) begin
                    decision  <= win_idx;
                    max_score <= win_val;
                    valid_out <= 1'b1;
                    cnt       <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_fc_argmax_comparator.sv
// Bench for fc_argmax_comparator: a frame-level reference model collects the
// scores of each frame, picks the first index holding the largest value,
// and a compare process checks every output one time unit after each edge.
// Directed sequences add hand-computed literal expectations.

module tb_fc_argmax_comparator;

    localparam int INPUT_BITS = 12;
    localparam int NUM_CLASS  = 10;
    localparam int INDEX_BITS = 4;

    logic                  clk;
    logic                  rst;
    logic                  valid_in;
    logic [INPUT_BITS-1:0] data_in;
    logic [INDEX_BITS-1:0] decision;
    logic [INPUT_BITS-1:0] max_score;
    logic                  valid_out;

    int tests;
    int fails;

    fc_argmax_comparator #(
        .INPUT_BITS (INPUT_BITS),
        .NUM_CLASS  (NUM_CLASS),
        .INDEX_BITS (INDEX_BITS)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .valid_in  (valid_in),
        .data_in   (data_in),
        .decision  (decision),
        .max_score (max_score),
        .valid_out (valid_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int frame[$];
    int m_dec;
    int m_max;
    int m_vo;
    int cyc;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            frame.delete();
            m_dec = 0;
            m_max = 0;
            m_vo  = 0;
        end else begin
            cyc++;
            m_vo = 0;
            if (valid_in) begin
                int best;
                frame.push_back(int'($signed(data_in)));
                if (frame.size() == NUM_CLASS) begin
                    best = 0;
                    for (int i = 1; i < NUM_CLASS; i++)
                        if (frame[i] > frame[best]) best = i;
                    m_dec = best;
                    m_max = frame[best];
                    m_vo  = 1;
                    frame.delete();
                end
            end
        end
    end

    // ---------------- compare process ----------------
    int pulses;
    int pulse_cyc[$];

    always @(posedge clk) begin
        #1;
        check("model_valid_out", int'(valid_out), m_vo);
        check("model_decision", int'(decision), m_dec);
        check("model_max_score", int'($signed(max_score)), m_max);
        if (valid_out) begin
            pulses++;
            pulse_cyc.push_back(cyc);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic send_score(input int v);
        valid_in = 1'b1;
        data_in  = INPUT_BITS'(v);
        @(negedge clk);
        valid_in = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            valid_in = 1'b0;
            data_in  = INPUT_BITS'($urandom_range(0, 4095));
            @(negedge clk);
        end
    endtask

    task automatic send_frame(input int s[NUM_CLASS], input int max_gap);
        for (int i = 0; i < NUM_CLASS; i++) begin
            send_score(s[i]);
            if (max_gap > 0 && i != NUM_CLASS - 1) idle($urandom_range(0, max_gap));
        end
    endtask

    task automatic check_result(input string name, input int dec, input int mx);
        check({name, "_valid"}, int'(valid_out), 1);
        check({name, "_decision"}, int'(decision), dec);
        check({name, "_max"}, int'($signed(max_score)), mx);
        @(negedge clk);
        check({name, "_valid_drop"}, int'(valid_out), 0);
    endtask

    int basic[NUM_CLASS]  = '{5, -3, 17, 2, 40, 1, 0, -100, 39, 7};
    int all_neg[NUM_CLASS] = '{-2048, -2048, -2048, -2048, -2048, -2048, -2048, -2048, -2048, -2048};
    int ties[NUM_CLASS]   = '{0, 1, 2, 12, -5, 11, 3, 4, 12, 10};
    int last_max[NUM_CLASS] = '{2046, 0, -1, 5, 2046, 100, -2048, 7, 8, 2047};
    int frame_a[NUM_CLASS] = '{0, 100, 3, -4, 99, 5, 6, 7, 8, 9};
    int frame_b[NUM_CLASS] = '{-10, -20, 30, 0, 1, 2, 500, 499, -500, 3};
    int fresh[NUM_CLASS]  = '{1, 2, 300, 4, 5, 6, 7, 8, 9, 299};

    initial begin
        int p0;
        tests    = 0;
        fails    = 0;
        pulses   = 0;
        cyc      = 0;
        rst      = 1'b0;
        valid_in = 1'b0;
        data_in  = '0;

        // Reset held with random traffic: outputs stay cleared
        @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            valid_in = 1'($urandom_range(0, 1));
            data_in  = INPUT_BITS'($urandom_range(0, 4095));
            @(negedge clk);
        end
        check("reset_valid_out", int'(valid_out), 0);
        check("reset_decision", int'(decision), 0);
        check("reset_max_score", int'(max_score), 0);
        valid_in = 1'b0;
        rst      = 1'b1;
        @(negedge clk);

        // First frame after reset: exactly one pulse
        p0 = pulses;
        send_frame(basic, 0);
        check_result("basic", 4, 40);
        idle(3);
        check("basic_one_pulse", pulses - p0, 1);

        // All equal negatives keep index 0
        send_frame(all_neg, 0);
        check_result("all_neg", 0, -2048);

        // Tie between index 3 and 8 keeps 3
        send_frame(ties, 0);
        check_result("tie", 3, 12);

        // Maximum at the last index
        send_frame(last_max, 0);
        check_result("last_idx", 9, 2047);

        // Gapped input
        idle(2);
        send_frame(basic, 5);
        check_result("gapped", 4, 40);

        // Back-to-back frames
        idle(2);
        p0 = pulse_cyc.size();
        send_frame(frame_a, 0);
        check("b2b_a_valid", int'(valid_out), 1);
        check("b2b_a_decision", int'(decision), 1);
        check("b2b_a_max", int'($signed(max_score)), 100);
        for (int i = 0; i < NUM_CLASS; i++) begin
            send_score(frame_b[i]);
            if (i == 4) begin
                check("b2b_hold_decision", int'(decision), 1);
                check("b2b_hold_valid", int'(valid_out), 0);
            end
        end
        check_result("b2b_b", 6, 500);
        idle(2);
        if (pulse_cyc.size() >= p0 + 2)
            check("b2b_spacing", pulse_cyc[p0+1] - pulse_cyc[p0], NUM_CLASS);
        else
            check("b2b_pulse_count", pulse_cyc.size() - p0, 2);

        // Mid-frame reset discards partial frame
        for (int i = 0; i < 6; i++) send_score(50 + i);
        rst = 1'b0;
        #1;
        check("midrst_decision", int'(decision), 0);
        check("midrst_max", int'(max_score), 0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        p0 = pulses;
        send_frame(fresh, 0);
        check_result("midrst", 2, 300);
        idle(3);
        check("midrst_one_pulse", pulses - p0, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/fc_argmax_comparator.md
# fc_argmax_comparator

Streaming arg-max unit at the tail of the MNIST CNN pipeline. It receives the fully-connected layer's class scores serially, one signed score per valid cycle, in class order 0..NUM_CLASS-1. After the last score of a frame it emits the index of the largest score as the classification decision, together with a one-cycle valid pulse. It then re-arms for the next frame.

## Interface
Parameters:
- INPUT_BITS, 12, width of each signed two's-complement class score.
- NUM_CLASS, 10, number of scores per frame; must be ≥2.
- INDEX_BITS, 4, width of decision; must satisfy 2^INDEX_BITS ≥ NUM_CLASS.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous and active-low; clears all state immediately.
- valid_in  in  1  data_in carries a valid score this cycle.
- data_in  in  INPUT_BITS  signed class score.
- decision  out  INDEX_BITS  index of the maximum score of the last completed frame.
- max_score  out  INPUT_BITS  signed value of that maximum score.
- valid_out  out  1  one-cycle pulse: decision/max_score just updated.

## Operation
- Internal state: sample counter cnt (0..NUM_CLASS-1), running maximum run_max (signed INPUT_BITS), running index run_idx (INDEX_BITS).
- Score k of a frame is the k-th valid_in cycle since reset or since the previous frame completed; its class index is k.
- Cycles with valid_in=0 hold all state; gaps between scores of any length are allowed.
- Valid sample with cnt=0: run_max←data_in, run_idx←0 unconditionally; cnt←1.
- Valid sample with 0<cnt<NUM_CLASS-1: if data_in > run_max (signed, strict), then run_max←data_in and run_idx←cnt; cnt←cnt+1.
- Valid sample with cnt=NUM_CLASS-1 (last score):
  - Final winner = this sample if data_in > run_max (strict), else run_max/run_idx.
  - decision←winner index, max_score←winner value, valid_out←1, cnt←0.
- Tie rule: the strict comparison makes equal scores keep the lower index.
- decision and max_score hold their value until the next frame completes.
- valid_out is 0 on every cycle except the one following a last-score cycle.
- Comparison is signed. Negative scores are legal; a frame of all-negative scores still returns the index of the least negative score.
- No saturation and no arithmetic beyond the compare; widths are preserved.

## Timing
- Reset (rst=0, asynchronous): cnt=0, run_max=0, run_idx=0, decision=0, max_score=0, valid_out=0. Deassertion is synchronous-safe; the first valid_in after release is score 0.
- Reset asserted mid-frame discards the partial frame; no valid_out is produced for it.
- Latency: valid_out is high in the cycle immediately after the edge that captured score NUM_CLASS-1 (1-cycle latency).
- Back-to-back frames: score 0 of the next frame may arrive in the cycle right after the last score. It is accepted while valid_out is high, so throughput is one score per cycle.
- No backpressure; the block always accepts valid_in.

## Test plan
- Reset: hold rst=0 with random valid_in/data_in -> decision=0, max_score=0, valid_out=0 throughout; release, then feed 10 scores -> exactly one valid_out pulse.
- Basic arg-max: scores 5,-3,17,2,40,1,0,-100,39,7 on consecutive cycles -> one cycle after the 10th score, valid_out=1, decision=4, max_score=40; valid_out=0 the following cycle.
- Ties and negatives: all ten scores = -2048 -> decision=0, max_score=-2048. Scores with 12 at indices 3 and 8, others lower -> decision=3. Maximum at the last index (score 2047 at index 9) -> decision=9.
- Gapped input: same frame as the basic case with valid_in low for 0–5 random cycles between scores -> same decision=4, max_score=40; valid_out timing one cycle after the 10th valid score.
- Back-to-back frames: frame A (max at 1), then frame B (max at 6) starting the cycle after A's last score -> two pulses exactly 10 cycles apart, decisions 1 then 6; decision holds 1 between the pulses.
- Mid-frame reset: 6 scores, then assert rst, then 10 fresh scores (max at 2) -> only one pulse, decision=2.
